// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the HI/LO mult/div sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        WRITE,
        FAULT
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;

    localparam logic [1:0] EXC_OK      = 2'b00;
    localparam logic [1:0] EXC_DIVZ    = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL = 2'b11;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/completion handshake between the main control FSM and the sequencer.
interface muldiv_ctrl_if;

    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_kind;
    logic [31:0] operand_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [1:0]  exc;

    modport master (
        output op_valid, op_kind, operand_b, abort,
        input  op_ready, busy, done, exc
    );

    modport slave (
        input  op_valid, op_kind, operand_b, abort,
        output op_ready, busy, done, exc
    );

endinterface

// File: rtl/muldiv_timer.sv
// Clearable up-counter with an expiry flag one count before TIMEOUT.
module muldiv_timer
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared HI/LO path: launches the multiplier or divider,
// waits for its done pulse and commits HI/LO, or reports an exception.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    muldiv_ctrl_if.slave        bus,
    output logic                mult_start,
    input  logic                mult_done,
    output logic                div_start,
    input  logic                div_done,
    output logic                divmult_sel,
    output logic                hi_we,
    output logic                lo_we
);

    state_t     state_q, state_d;
    logic [1:0] kind_q, kind_d;
    logic [1:0] exc_q, exc_d;
    logic       unit_done;
    logic       expired;
    logic       timer_clear;
    logic [CNT_W-1:0] count;

    assign timer_clear = (state_q != WAIT) || bus.abort;

    muldiv_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (timer_clear),
        .en      (state_q == WAIT),
        .count   (count),
        .expired (expired)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            kind_q  <= OP_MULT;
            exc_q   <= EXC_OK;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        exc_d     = exc_q;
        unit_done = (kind_q == OP_MULT) ? mult_done : div_done;

        case (state_q)
            IDLE: begin
                if (bus.op_valid && !bus.abort) begin
                    kind_d = bus.op_kind;
                    if (bus.op_kind[1]) begin
                        state_d = FAULT;
                        exc_d   = EXC_ILLEGAL;
                    end else if (bus.op_kind == OP_DIV && bus.operand_b == '0) begin
                        state_d = FAULT;
                        exc_d   = EXC_DIVZ;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                // Done beats timeout when both happen in the same cycle.
                if (unit_done) begin
                    state_d = WRITE;
                end else if (expired) begin
                    state_d = FAULT;
                    exc_d   = EXC_TIMEOUT;
                end
            end
            WRITE:   state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
        end

        bus.op_ready = (state_q == IDLE);
        bus.busy     = (state_q != IDLE);
        mult_start   = (state_q == START) && (kind_q == OP_MULT) && !bus.abort;
        div_start    = (state_q == START) && (kind_q != OP_MULT) && !bus.abort;
        hi_we        = (state_q == WRITE) && !bus.abort;
        lo_we        = (state_q == WRITE) && !bus.abort;
        bus.done     = (state_q == WRITE || state_q == FAULT) && !bus.abort;
        bus.exc      = (state_q == FAULT) ? exc_q : EXC_OK;
        divmult_sel  = (kind_q == OP_MULT) &&
                       (state_q == START || state_q == WAIT || state_q == WRITE);
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the shared HI/LO path of the multicycle CPU. It accepts a MULT or DIV request from the main control FSM and launches the selected iterative unit. It waits for that unit's done pulse and then commits both HI and LO in one cycle. Divide-by-zero, illegal op codes and a hung unit are reported as exception codes, so the main FSM's mult/div wait states reduce to a single valid/done handshake.

Parameters:
TIMEOUT, 64, max WAIT cycles before a unit is declared hung (>=2)
CNT_W, $clog2(TIMEOUT+1), width of the wait counter

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low; clears all state
op_valid  in  1  request from control FSM, held until accepted
op_ready  out  1  high only in IDLE; accept = op_valid & op_ready at a rising edge
op_kind  in  2  00 MULT, 01 DIV, 1x illegal
operand_b  in  32  divisor (B register output), used only for the zero check
abort  in  1  synchronous cancel, highest priority after Reset
mult_start  out  1  one-cycle start pulse to multiplier
mult_done  in  1  multiplier done pulse
div_start  out  1  one-cycle start pulse to divider
div_done  in  1  divider done pulse
divmult_sel  out  1  HI/LO source mux select: 0 divider, 1 multiplier
hi_we  out  1  HI register load
lo_we  out  1  LO register load
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
exc  out  2  valid with done: 00 ok, 01 div-by-zero, 10 timeout, 11 illegal op

Behaviour:
- Reset (Reset=0, async): state IDLE, counter 0, latched kind MULT, all outputs 0 except op_ready=1. divmult_sel=0.
- States: IDLE, START, WAIT, WRITE, FAULT.
- IDLE:
  - op_ready=1.
  - On accept, latch op_kind into kind_q and route by kind:
    - MULT, or DIV with operand_b!=0 -> START.
    - DIV with operand_b==0 -> FAULT, exc_q=01.
    - op_kind 1x -> FAULT, exc_q=11.
- START (1 cycle):
  - Assert mult_start if kind_q=MULT, else div_start.
  - Clear counter. Go to WAIT.
  - Done inputs are ignored in this cycle.
- WAIT:
  - Counter increments each cycle.
  - Only the done input of the selected unit is observed; the other is ignored.
  - Selected done=1 -> WRITE.
  - Otherwise, counter==TIMEOUT-1 -> FAULT with exc_q=10.
  - Done and timeout in the same cycle: done wins.
- WRITE (1 cycle): hi_we=lo_we=1, done=1, exc=00. Go to IDLE.
- FAULT (1 cycle): done=1, exc=exc_q. No HI/LO write. Go to IDLE.
- divmult_sel = (kind_q==MULT), held constant from START through WRITE so the mux is stable during the write.
- All outputs are decoded from registered state/kind/exc (Moore); there are no input-to-output paths except abort gating.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; counter cleared.
  - hi_we, lo_we, done, mult_start, div_start are forced 0 combinationally in that cycle.
  - No done is produced for the aborted op.
  - abort in IDLE blocks acceptance.
- Minimum accept-to-done latency: 3 cycles (START, 1 WAIT, WRITE).
- Fault paths complete 1 cycle after accept.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately following WRITE/FAULT.
- A done pulse from a unit while IDLE or FAULT is ignored.
- Reset asserted mid-operation: immediate return to the reset values; no write is issued.

Decomposition:
- Package muldiv_pkg:
  - state enum (IDLE, START, WAIT, WRITE, FAULT).
  - op_kind constants OP_MULT=2'b00, OP_DIV=2'b01.
  - exc constants EXC_OK, EXC_DIVZ, EXC_TIMEOUT, EXC_ILLEGAL.
- One sub-module: muldiv_timer. A CNT_W-bit clearable up-counter with an expiry flag at TIMEOUT-1, instantiated once for the WAIT timeout.

Test Plan:
- MULT, mult_done 5 cycles after mult_start -> mult_start one pulse; hi_we=lo_we=1, done=1, exc=00, divmult_sel=1 in the same cycle; op_ready back 1 cycle later.
- DIV with operand_b=7, div_done in the first WAIT cycle -> div_start one pulse; done 3 cycles after accept; divmult_sel=0; exc=00.
- DIV with operand_b=0 -> no div_start, no hi_we/lo_we; done=1 and exc=01 one cycle after accept.
- MULT with mult_done never asserted, TIMEOUT=8 -> done=1, exc=10 after 8 WAIT cycles; no HI/LO write. Repeat with mult_done on the 8th WAIT cycle -> WRITE, exc=00.
- DIV with a spurious mult_done during WAIT -> ignored; only div_done completes. op_kind=2'b10 -> done, exc=11.
- abort asserted during WAIT, and separately during WRITE -> no done, hi_we=lo_we=0, IDLE next cycle. Reset=0 mid-WAIT -> busy=0 and op_ready=1 immediately (async).
